// File: rtl/uart_echo_tester.sv
// Host-side UART loopback tester: sends one 8N1 test byte, then receives and
// checks the echoed frames, counting good and bad echoes until done or timeout.
module uart_echo_tester #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int DATA_WIDTH     = 8,
  parameter int ECHO_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 75_000_000
) (
  input  logic                  iCLK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_byte,
  output logic                  serial_out,
  input  logic                  serial_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [3:0]            echo_cnt,
  output logic [3:0]            err_cnt,
  output logic                  timeout_flag,
  output logic [DATA_WIDTH-1:0] last_rx
);

  localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CYC_W       = $clog2(BIT_CYCLES + 1);
  localparam int TO_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W       = $clog2(DATA_WIDTH + 2);
  localparam logic [IDX_W-1:0] STOP_IDX = IDX_W'(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_ECHO, RECV, CHECK, DONE
  } state_t;

  state_t state, state_next;

  logic                  sync_a, sync_b, sync_c;
  logic                  tx_line;
  logic [CYC_W-1:0]      cyc_cnt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_inc;
  logic [TO_W-1:0]       to_cnt;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  rx_stop;
  logic [DATA_WIDTH+1:0] frame;

  logic       accept, bit_end, rx_sample, fall, to_hit, go_timeout;
  logic       data_ok, pass_next;
  logic [3:0] echo_next, err_next, total_next;

  assign serial_out = tx_line;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign frame      = {1'b1, tx_data, 1'b0};
  assign idx_inc    = idx + IDX_W'(1);

  // serial_in is asynchronous: two flops to synchronize, a third for edge detect
  assign fall    = sync_c & ~sync_b;
  assign bit_end = (cyc_cnt == CYC_W'(BIT_CYCLES - 1));
  assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iCLK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    go_timeout = 1'b0;
    rx_sample  = (idx == '0) ? (cyc_cnt == CYC_W'(HALF_CYCLES - 1)) : bit_end;
    data_ok    = rx_stop && (rx_sh == tx_data);
    echo_next  = data_ok ? echo_cnt + 4'd1 : echo_cnt;
    err_next   = data_ok ? err_cnt : err_cnt + 4'd1;
    total_next = echo_next + err_next;
    pass_next  = (echo_next == 4'(ECHO_COUNT)) && (err_next == 4'd0);
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (bit_end && idx == STOP_IDX) state_next = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        if (fall) begin
          state_next = RECV;
        end else if (to_hit) begin
          go_timeout = 1'b1;
          state_next = DONE;
        end
      end
      RECV: begin
        if (rx_sample) begin
          // a line already back high at mid start bit was only a glitch
          if (idx == '0 && sync_b) state_next = WAIT_ECHO;
          else if (idx == STOP_IDX) state_next = CHECK;
        end
      end
      CHECK: begin
        if (total_next == 4'(ECHO_COUNT)) state_next = DONE;
        else                              state_next = WAIT_ECHO;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50) begin
    if (reset) begin
      sync_a       <= 1'b1;
      sync_b       <= 1'b1;
      sync_c       <= 1'b1;
      tx_line      <= 1'b1;
      cyc_cnt      <= '0;
      idx          <= '0;
      to_cnt       <= '0;
      echo_cnt     <= 4'd0;
      err_cnt      <= 4'd0;
      timeout_flag <= 1'b0;
      pass         <= 1'b0;
      last_rx      <= '0;
    end else begin
      sync_a <= serial_in;
      sync_b <= sync_a;
      sync_c <= sync_b;
      // the idle-gap counter only runs while waiting and restarts from 0 on every entry
      to_cnt <= (state == WAIT_ECHO) ? to_cnt + TO_W'(1) : '0;
      case (state)
        IDLE: begin
          if (accept) begin
            echo_cnt     <= 4'd0;
            err_cnt      <= 4'd0;
            pass         <= 1'b0;
            timeout_flag <= 1'b0;
            tx_line      <= 1'b0;
            cyc_cnt      <= '0;
            idx          <= '0;
          end
        end
        SEND: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (idx == STOP_IDX) begin
              tx_line <= 1'b1;
            end else begin
              idx     <= idx_inc;
              tx_line <= frame[idx_inc];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        WAIT_ECHO: begin
          if (fall) begin
            cyc_cnt <= '0;
            idx     <= '0;
          end
          if (go_timeout) begin
            timeout_flag <= 1'b1;
            pass         <= 1'b0;
          end
        end
        RECV: begin
          if (rx_sample) begin
            cyc_cnt <= '0;
            idx     <= idx_inc;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        CHECK: begin
          last_rx  <= rx_sh;
          echo_cnt <= echo_next;
          err_cnt  <= err_next;
          pass     <= pass_next;
        end
        default: ;
      endcase
    end
  end

  // data registers: no reset, written only under FSM control
  always_ff @(posedge iCLK_50) begin
    if (state == IDLE && accept) tx_data <= tx_byte;
    if (state == RECV && rx_sample) begin
      if (idx != '0 && idx <= LAST_DATA_IDX) rx_sh <= {sync_b, rx_sh[DATA_WIDTH-1:1]};
      if (idx == STOP_IDX) rx_stop <= sync_b;
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: table of echo scenarios (hand-written plus random,
// expectations from a frame-level reference model) and a few corner sequences.
module tb_uart_echo_tester;

  localparam int BITC = 16;

  logic       clk = 1'b0;
  logic       reset, start, serial_in;
  logic [7:0] tx_byte;
  logic       serial_out, busy, done, pass, timeout_flag;
  logic [3:0] echo_cnt, err_cnt;
  logic [7:0] last_rx;

  always #5 clk = ~clk;

  uart_echo_tester #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_WIDTH(8),
    .ECHO_COUNT(4), .TIMEOUT_CYCLES(2000)
  ) dut (
    .iCLK_50(clk), .reset(reset), .start(start), .tx_byte(tx_byte),
    .serial_out(serial_out), .serial_in(serial_in), .busy(busy), .done(done),
    .pass(pass), .echo_cnt(echo_cnt), .err_cnt(err_cnt),
    .timeout_flag(timeout_flag), .last_rx(last_rx)
  );

  int nvec = 0;
  int nbad = 0;
  int cycle = 0;
  int done_pulses = 0;
  int done_cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) if (done) begin
    done_pulses <= done_pulses + 1;
    done_cycle  <= cycle;
  end

  typedef struct packed {
    logic [7:0]      tx;
    logic [2:0]      nfr;
    logic [3:0][7:0] d;
    logic [3:0]      stop;
    logic [3:0]      echo;
    logic [3:0]      err;
    logic            to;
    logic            pass;
    logic [7:0]      last;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Frame-level reference: an echo is good when its stop bit is 1 and its data equals the sent byte.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int good;
    r = v;
    good = 0;
    for (int f = 0; f < int'(v.nfr); f++)
      if (v.stop[f] && v.d[f] == v.tx) good++;
    r.echo = 4'(good);
    r.err  = 4'(int'(v.nfr) - good);
    r.to   = (v.nfr < 3'd4);
    r.pass = (good == 4);
    r.last = v.d[int'(v.nfr) - 1];
    return r;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    logic [9:0] fr;
    fr = {stopb, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      serial_in = fr[b];
      repeat (BITC) tick();
    end
    serial_in = 1'b1;
  endtask

  task automatic start_tx(input logic [7:0] b);
    logic [9:0] fr;
    int bad;
    fr = {1'b1, b, 1'b0};
    tx_byte = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    tx_byte = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < BITC; c++) begin
        if (serial_out !== fr[k] || busy !== 1'b1) bad++;
        tick();
      end
      chk($sformatf("tx_bit%0d_bad_cycles", k), bad, 0);
    end
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 4000 && done_pulses == base; i++) tick();
    chk("done_seen", int'(done_pulses != base), 1);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int base, end_cyc, lat;
    base = done_pulses;
    start_tx(v.tx);
    end_cyc = cycle;
    for (int f = 0; f < int'(v.nfr); f++) begin
      repeat ($urandom_range(20, 300)) tick();
      send_frame(v.d[f], v.stop[f]);
      end_cyc = cycle;
    end
    wait_done(base);
    repeat (3) tick();
    chk($sformatf("v%0d_done_pulses", n), done_pulses - base, 1);
    chk($sformatf("v%0d_echo_cnt", n), int'(echo_cnt), int'(v.echo));
    chk($sformatf("v%0d_err_cnt", n), int'(err_cnt), int'(v.err));
    chk($sformatf("v%0d_timeout", n), int'(timeout_flag), int'(v.to));
    chk($sformatf("v%0d_pass", n), int'(pass), int'(v.pass));
    chk($sformatf("v%0d_last_rx", n), int'(last_rx), int'(v.last));
    chk($sformatf("v%0d_busy_after", n), int'(busy), 0);
    if (v.to) begin
      lat = done_cycle - end_cyc;
      nvec++;
      if (lat < 1985 || lat > 2010) begin
        nbad++;
        $display("FAIL v%0d_timeout_latency: got %0d cycles, required 1985..2010", n, lat);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int base;

    tbl[0] = '{tx:8'hA5, nfr:3'd4, d:{8'hA5, 8'hA5, 8'hA5, 8'hA5}, stop:4'b1111,
               echo:4'd4, err:4'd0, to:1'b0, pass:1'b1, last:8'hA5};
    tbl[1] = '{tx:8'hA5, nfr:3'd4, d:{8'hA5, 8'hA5, 8'h5A, 8'hA5}, stop:4'b1111,
               echo:4'd3, err:4'd1, to:1'b0, pass:1'b0, last:8'hA5};
    tbl[2] = '{tx:8'hA5, nfr:3'd4, d:{8'hA5, 8'hA5, 8'hA5, 8'hA5}, stop:4'b1101,
               echo:4'd3, err:4'd1, to:1'b0, pass:1'b0, last:8'hA5};
    tbl[3] = '{tx:8'hA5, nfr:3'd2, d:{8'h00, 8'h00, 8'hA5, 8'hA5}, stop:4'b1111,
               echo:4'd2, err:4'd0, to:1'b1, pass:1'b0, last:8'hA5};
    for (int i = 4; i < 10; i++) begin
      v = '0;
      v.tx  = 8'($urandom);
      v.nfr = 3'($urandom_range(1, 4));
      for (int f = 0; f < 4; f++) begin
        v.d[f]    = ($urandom_range(0, 1) == 1) ? v.tx : 8'($urandom);
        v.stop[f] = ($urandom_range(0, 3) != 0);
      end
      tbl[i] = model(v);
    end

    // reset state
    reset = 1'b1; start = 1'b0; serial_in = 1'b1; tx_byte = 8'h00;
    repeat (3) tick();
    chk("rst_serial_out", int'(serial_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_echo_cnt", int'(echo_cnt), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_timeout", int'(timeout_flag), 0);
    chk("rst_last_rx", int'(last_rx), 0);
    reset = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], i);
      repeat (5) tick();
    end

    // glitch in WAIT_ECHO plus a start pulse while busy
    base = done_pulses;
    start_tx(8'h3C);
    repeat (100) tick();
    send_frame(8'h3C, 1'b1);
    repeat (50) tick();
    serial_in = 1'b0;
    repeat (4) tick();
    serial_in = 1'b1;
    repeat (40) tick();
    chk("glitch_echo_cnt", int'(echo_cnt), 1);
    chk("glitch_err_cnt", int'(err_cnt), 0);
    chk("glitch_busy", int'(busy), 1);
    tx_byte = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    chk("busy_start_serial_out", int'(serial_out), 1);
    for (int f = 0; f < 3; f++) begin
      repeat (150) tick();
      send_frame(8'h3C, 1'b1);
    end
    wait_done(base);
    repeat (2) tick();
    chk("glitch_final_echo", int'(echo_cnt), 4);
    chk("glitch_final_err", int'(err_cnt), 0);
    chk("glitch_final_pass", int'(pass), 1);
    chk("glitch_done_pulses", done_pulses - base, 1);

    // reset during SEND
    tx_byte = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    chk("midsend_serial_out", int'(serial_out), 0);
    reset = 1'b1;
    tick();
    chk("midsend_rst_serial_out", int'(serial_out), 1);
    chk("midsend_rst_busy", int'(busy), 0);
    chk("midsend_rst_echo", int'(echo_cnt), 0);
    reset = 1'b0;
    tick();

    // start coincident with reset
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    chk("start_with_reset_busy", int'(busy), 0);
    chk("start_with_reset_line", int'(serial_out), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
